// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and opcode helpers for mc_alu
// Purpose: WIDTH-independent definitions used by mc_alu and alu_iter_unit.
// Ports: none (package).
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || is_div_op(op);
  endfunction

  // Only 1011 and 1101 are unassigned.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op != 4'b1011) && (op != 4'b1101);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - iterative shift-add multiply and restoring divide
// Purpose: runs WIDTH iterations after a start pulse and then holds done
//          until the next clock edge.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : load operands and begin (single-cycle pulse)
//   op             : opcode (MUL, DIVU or REMU)
//   n1, n2         : operands (multiplicand/multiplier or dividend/divisor)
//   done           : result valid for this cycle
//   result         : product low bits, quotient or remainder
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_is_div;
  logic             r_is_rem;
  // r_acc: product accumulator / partial remainder
  // r_q  : multiplier (shifted right) / quotient (shifted in from the right)
  // r_c  : multiplicand (shifted left) / divisor
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_c;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_sum;

  // Remainder shifted left by one with the next dividend bit; one extra bit
  // keeps the trial subtraction exact for divisors near 2^WIDTH.
  assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_c};
  assign w_fits   = ~w_diff[WIDTH];
  assign w_sum    = r_acc + r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_is_rem <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_c      <= '0;
    end else if (start) begin
      r_cnt    <= CW'(WIDTH);
      r_busy   <= 1'b1;
      r_is_div <= is_div_op(op);
      r_is_rem <= (op == OP_REMU);
      r_acc    <= '0;
      if (is_div_op(op)) begin
        r_q <= n1;
        r_c <= n2;
      end else begin
        r_q <= n2;
        r_c <= n1;
      end
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_is_div) begin
          r_acc <= w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_fits};
        end else begin
          if (r_q[0]) begin
            r_acc <= w_sum;
          end
          r_c <= r_c << 1;
          r_q <= r_q >> 1;
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign done   = r_busy && (r_cnt == '0);
  assign result = r_is_div ? (r_is_rem ? r_acc : r_q) : r_acc;

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU with valid/ready handshake
// Purpose: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU,
//          registered result held until the consumer takes it.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid / in_ready         : request handshake
//   n1, n2, aluControlSignal    : operands and opcode
//   out_valid / out_ready       : result handshake
//   aluOut                      : registered result
//   aluZero, aluOvf, divZero,
//   illegal                     : result flags, 0 whenever out_valid = 0
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic [3:0]       aluControlSignal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             aluZero,
  output logic             aluOvf,
  output logic             divZero,
  output logic             illegal
);

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_div_zero;
  logic             r_illegal;

  logic             w_accept;
  logic             w_n2_zero;
  logic             w_iter_start;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_result;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;
  logic             w_div_zero;
  logic             w_illegal;

  assign in_ready     = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_n2_zero    = (n2 == '0);
  // Divide by zero is answered immediately instead of iterating.
  assign w_iter_start = w_accept && is_iter_op(aluControlSignal) &&
                        !(is_div_op(aluControlSignal) && w_n2_zero);

  assign w_sum   = n1 + n2;
  assign w_diff  = n1 - n2;
  assign w_shamt = n2[SHW-1:0];

  always_comb begin
    w_result   = '0;
    w_ovf      = 1'b0;
    w_div_zero = 1'b0;
    w_illegal  = 1'b0;
    case (aluControlSignal)
      OP_AND:  w_result = n1 & n2;
      OP_OR:   w_result = n1 | n2;
      OP_XOR:  w_result = n1 ^ n2;
      OP_NOR:  w_result = ~(n1 | n2);
      OP_ADD: begin
        w_result = w_sum;
        w_ovf    = (n1[WIDTH-1] == n2[WIDTH-1]) && (w_sum[WIDTH-1] != n1[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_diff;
        w_ovf    = (n1[WIDTH-1] != n2[WIDTH-1]) && (w_diff[WIDTH-1] != n1[WIDTH-1]);
      end
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(n1) < $signed(n2))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (n1 < n2)};
      OP_SLL:  w_result = n1 << w_shamt;
      OP_SRL:  w_result = n1 >> w_shamt;
      OP_SRA:  w_result = $unsigned($signed(n1) >>> w_shamt);
      OP_DIVU: begin
        w_result   = '1;
        w_div_zero = 1'b1;
      end
      OP_REMU: begin
        w_result   = n1;
        w_div_zero = 1'b1;
      end
      OP_MUL:  w_result = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_iter_start),
    .op     (aluControlSignal),
    .n1     (n1),
    .n2     (n2),
    .done   (w_iter_done),
    .result (w_iter_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_div_zero  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_iter_start) begin
              r_state     <= ST_BUSY;
              r_out_valid <= 1'b0;
              r_alu_out   <= '0;
              r_zero      <= 1'b0;
              r_ovf       <= 1'b0;
              r_div_zero  <= 1'b0;
              r_illegal   <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_alu_out   <= w_result;
              r_zero      <= (w_result == '0);
              r_ovf       <= w_ovf;
              r_div_zero  <= w_div_zero;
              r_illegal   <= w_illegal;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_iter_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_alu_out   <= w_iter_result;
            r_zero      <= (w_iter_result == '0);
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign aluOut    = r_alu_out;
  assign aluZero   = r_zero;
  assign aluOvf    = r_ovf;
  assign divZero   = r_div_zero;
  assign illegal   = r_illegal;

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (legal 8..64, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have ports n1 and n2, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port aluControlSignal, input, 4 bits: the opcode.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is held valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port aluOut, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port aluZero, output, 1 bit: set when aluOut == 0.
REQ-013 The block SHALL have port aluOvf, output, 1 bit: signed overflow, ADD/SUB only, else 0.
REQ-014 The block SHALL have port divZero, output, 1 bit: DIVU/REMU with n2 == 0.
REQ-015 The block SHALL have port illegal, output, 1 bit: the opcode is undefined.

Function
REQ-016 The block SHALL support these opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 0011 XOR, 1100 NOR, 0100 SLL, 0101 SRL, 1001 SRA, 1010 MUL (low WIDTH bits, unsigned), 1110 DIVU, 1111 REMU.
REQ-017 For an undefined opcode, the block SHALL produce aluOut = 0 with illegal = 1 and complete as a single-cycle op.
REQ-018 Shifts SHALL use n2[SHW-1:0] as the shift amount; SRA SHALL replicate n1[WIDTH-1].
REQ-019 The block SHALL have FSM states IDLE, BUSY and DONE; a request is accepted on the edge where in_valid && in_ready, and operands and opcode are captured there.
REQ-020 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); in_ready SHALL be 0 in BUSY.
REQ-021 On acceptance of a single-cycle op, the block SHALL go to DONE; aluOut, the flags and out_valid SHALL be registered on the accepting edge (latency 1).
REQ-022 On acceptance of MUL, DIVU or REMU, the block SHALL go to BUSY and run an iteration counter for WIDTH cycles (shift-add multiply, restoring divide), then go to DONE; out_valid SHALL rise exactly WIDTH+1 edges after acceptance.
REQ-023 For DIVU/REMU with n2 == 0, the block SHALL skip the iteration, set divZero = 1, and return DIVU = all ones and REMU = n1, with latency 1.
REQ-024 In DONE, aluOut and the flags SHALL be held stable while out_ready = 0.
REQ-025 In DONE, if out_ready = 1 and in_valid = 0, the block SHALL go to IDLE and out_valid SHALL fall on that edge.
REQ-026 In DONE, if out_ready = 1 and in_valid = 1, the block SHALL accept the new request on the same edge with no bubble.
REQ-027 aluZero, aluOvf, divZero and illegal SHALL be registered together with aluOut and valid only while out_valid = 1; otherwise they SHALL be 0.
REQ-028 Changes to the inputs while in BUSY SHALL be ignored.

Reset
REQ-029 While rst_n = 0, the block SHALL immediately set state = IDLE, out_valid = 0, aluOut = 0, all flags = 0 and the counter = 0; in_ready SHALL be 1 after reset.
REQ-030 A reset asserted during BUSY or DONE SHALL discard the operation in flight; no result SHALL be produced after release.

Structure
REQ-031 Opcode constants, state encodings and WIDTH-independent helpers SHALL live in the shared package alu_pkg.
REQ-032 The iterative multiply/divide datapath SHALL be the sub-module alu_iter_unit, with start, done, op, n1, n2, result and parameter WIDTH; mc_alu SHALL hold the FSM, the handshake and the single-cycle ops.

Verification (WIDTH=32)
REQ-033 ADD 0x7FFFFFFF + 0x00000001 -> aluOut 0x80000000, aluOvf = 1, aluZero = 0, out_valid the cycle after acceptance.
REQ-034 SUB 5 - 5 -> aluOut 0, aluZero = 1; SLT 0xFFFFFFFF, 1 -> 1; SLTU 0xFFFFFFFF, 1 -> 0; SRA 0x80000000 by 4 -> 0xF8000000; opcode 1101 -> 0 with illegal = 1.
REQ-035 MUL 0x00010000 * 0x00010000 -> aluOut 0, aluZero = 1, out_valid 33 edges after acceptance, in_ready = 0 throughout BUSY; MUL 1234 * 5678 -> 7006652.
REQ-036 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF with divZero = 1 and latency 1; REMU 9/0 -> 9.
REQ-037 Back-pressure: hold out_ready = 0 for 5 cycles -> aluOut stable and in_ready = 0; then assert out_ready with in_valid (OR 0xF0, 0x0F) -> old result retired, 0xFF valid on the next cycle with no bubble.
REQ-038 Drop rst_n for 1 cycle at iteration 10 of a MUL -> out_valid = 0 immediately, state IDLE, no result after release, next ADD completes normally.
